// File: rtl/instruction_fetch_stage.sv
// RV64 instruction fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Handles stall, redirect flush, halt on EBREAK and counts delivered instructions.
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] ifid_pc,
    output logic [63:0] ifid_pc4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fetch_misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [63:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halted_q, halted_d;
    logic        fetch_misalign_q, fetch_misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [63:0] redir_target;
    logic        redir_misaligned;

    // Low two target bits are dropped so fetch stays word-aligned; the sticky flag records the loss.
    assign redir_target     = {redirect_pc[63:2], 2'b00};
    assign redir_misaligned = |redirect_pc[1:0];

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        ifid_pc_d        = ifid_pc_q;
        ifid_pc4_d       = ifid_pc4_q;
        ifid_inst_d      = ifid_inst_q;
        ifid_valid_d     = ifid_valid_q;
        fetch_misalign_d = fetch_misalign_q;
        fetch_count_d    = fetch_count_q;

        case (state_q)
            BOOT: begin
                state_d      = RUN;
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
                if (redirect) begin
                    pc_d             = redir_target;
                    fetch_misalign_d = fetch_misalign_q | redir_misaligned;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d             = redir_target;
                    ifid_valid_d     = 1'b0;
                    ifid_inst_d      = NOP_INST;
                    fetch_misalign_d = fetch_misalign_q | redir_misaligned;
                end else if (!stall) begin
                    ifid_pc_d     = pc_q;
                    ifid_pc4_d    = pc_q + 64'd4;
                    ifid_inst_d   = imem_inst;
                    ifid_valid_d  = 1'b1;
                    pc_d          = pc_q + 64'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (imem_inst == EBREAK) state_d = HALT;
                end
            end
            HALT: begin
                // The EBREAK may sit under a not-yet-resolved branch, so a redirect revives fetch.
                if (redirect) begin
                    state_d          = RUN;
                    pc_d             = redir_target;
                    ifid_valid_d     = 1'b0;
                    ifid_inst_d      = NOP_INST;
                    fetch_misalign_d = fetch_misalign_q | redir_misaligned;
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
                end
            end
            default: state_d = BOOT;
        endcase

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= BOOT;
            pc_q             <= RESET_PC;
            ifid_pc_q        <= 64'h0;
            ifid_pc4_q       <= 64'h0;
            ifid_inst_q      <= NOP_INST;
            ifid_valid_q     <= 1'b0;
            halted_q         <= 1'b0;
            fetch_misalign_q <= 1'b0;
            fetch_count_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            ifid_pc_q        <= ifid_pc_d;
            ifid_pc4_q       <= ifid_pc4_d;
            ifid_inst_q      <= ifid_inst_d;
            ifid_valid_q     <= ifid_valid_d;
            halted_q         <= halted_d;
            fetch_misalign_q <= fetch_misalign_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign imem_addr      = pc_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_pc4       = ifid_pc4_q;
    assign ifid_inst      = ifid_inst_q;
    assign ifid_valid     = ifid_valid_q;
    assign halted         = halted_q;
    assign fetch_misalign = fetch_misalign_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed scenarios then randomized stall/redirect/reset traffic.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [63:0] redirect_pc, imem_addr, ifid_pc, ifid_pc4;
    logic [31:0] imem_inst, ifid_inst, fetch_count;
    logic        ifid_valid, halted, fetch_misalign;

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_misalign(fetch_misalign), .fetch_count(fetch_count)
    );

    // 64-word memory image, aliased across the address space by the low address bits.
    logic [31:0] mem [64];
    assign imem_inst = mem[imem_addr[7:2]];

    typedef struct {
        logic [63:0] pc, ipc, ipc4;
        logic [31:0] inst, cnt;
        logic        valid, halt, mis;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural view of the fetch stage.
    logic [63:0] m_pc, m_ipc, m_ipc4;
    logic [31:0] m_inst, m_cnt;
    logic        m_valid, m_halt, m_boot, m_mis;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic flush_to(input logic [63:0] rpc);
        m_pc    = {rpc[63:2], 2'b00};
        m_mis   = m_mis | (rpc[1:0] != 2'b00);
        m_valid = 1'b0;
        m_inst  = NOP;
    endtask

    task automatic cycle(input logic rst, input logic stl, input logic rd, input logic [63:0] rpc);
        logic [31:0] w;
        exp_t e;
        @(negedge clk);
        rst_n = rst; stall = stl; redirect = rd; redirect_pc = rpc;
        w = mem[m_pc[7:2]];
        if (!rst) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_ipc4 = 64'h0; m_inst = NOP; m_valid = 1'b0;
            m_halt = 1'b0; m_boot = 1'b1; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (rd) flush_to(rpc);
        end else if (rd) begin
            flush_to(rpc);
            m_halt = 1'b0;
        end else if (m_halt) begin
            if (!stl) begin m_valid = 1'b0; m_inst = NOP; end
        end else if (!stl) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 64'd4; m_inst = w; m_valid = 1'b1;
            m_pc = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
            m_halt = (w == EBRK);
        end
        e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.inst = m_inst; e.cnt = m_cnt;
        e.valid = m_valid; e.halt = m_halt; e.mis = m_mis;
        q.push_back(e);
    endtask

    // Monitor: every edge that had stimulus behind it yields one expected snapshot.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("imem_addr", imem_addr, e.pc);
            check("ifid_pc", ifid_pc, e.ipc);
            check("ifid_pc4", ifid_pc4, e.ipc4);
            check("ifid_inst", {32'h0, ifid_inst}, {32'h0, e.inst});
            check("ifid_valid", {63'h0, ifid_valid}, {63'h0, e.valid});
            check("halted", {63'h0, halted}, {63'h0, e.halt});
            check("fetch_misalign", {63'h0, fetch_misalign}, {63'h0, e.mis});
            check("fetch_count", {32'h0, fetch_count}, {32'h0, e.cnt});
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        m_pc = 64'h0; m_ipc = 64'h0; m_ipc4 = 64'h0; m_inst = NOP; m_valid = 1'b0;
        m_halt = 1'b0; m_boot = 1'b1; m_mis = 1'b0; m_cnt = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = (($urandom & 32'hFFFF_FF7F) | 32'h3);
        mem[0] = 32'h0285_3483;
        mem[1] = 32'h0054_8513;

        // Reset, boot bubble, first two fetches.
        cycle(1'b0, 1'b0, 1'b0, 64'h0);
        cycle(1'b0, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        // Stall three cycles at pc 8, then resume.
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        // Redirect beats stall.
        cycle(1'b1, 1'b1, 1'b1, 64'h40);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        // Misaligned redirect, then aligned ones keep the sticky flag.
        cycle(1'b1, 1'b0, 1'b1, 64'h46);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b1, 64'h80);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        // EBREAK halt, bubble, stall hold, redirect out of halt.
        mem[2] = EBRK;
        cycle(1'b1, 1'b0, 1'b1, 64'h8);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 1'b1, 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        // Halted, then stall + halt immediately after EBREAK capture.
        cycle(1'b1, 1'b0, 1'b1, 64'h8);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 64'h0);
        // Reset wins over stall and redirect.
        cycle(1'b0, 1'b1, 1'b1, 64'h123);
        cycle(1'b1, 1'b1, 1'b1, 64'h21);
        cycle(1'b1, 1'b0, 1'b0, 64'h0);

        // Randomized traffic with sprinkled EBREAKs.
        for (int i = 0; i < 64; i++) if ($urandom_range(15) == 0) mem[i] = EBRK;
        for (int i = 0; i < 3000; i++) begin
            logic r, s, d;
            logic [63:0] t;
            r = ($urandom_range(99) != 0);
            s = ($urandom_range(3) == 0);
            d = ($urandom_range(9) == 0);
            t = {$urandom, $urandom};
            if ($urandom_range(3) != 0) t = {56'h0, t[7:0]};
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            cycle(r, s, d, t);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
